// File: rtl/seq_divider_16bit.sv
// Sequential restoring shift-subtract divider: FULL_WIDTH dividend over DATA_WIDTH divisor,
// one quotient bit per clock, start/done handshake matching the MAC companion block.
module seq_divider_16bit #(
  parameter int DATA_WIDTH = 16,
  localparam int FULL_WIDTH = 2 * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [FULL_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  busy,
  output logic                  done,
  output logic                  div_zero,
  output logic [FULL_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(FULL_WIDTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FULL_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One restoring step. The stored partial remainder is kept DATA_WIDTH wide because it
  // is always below the divisor; the extra top bit only exists in the shifted trial value.
  // Returns {new partial remainder, quotient bit}.
  function automatic logic [DATA_WIDTH:0] div_step(
    input logic [DATA_WIDTH-1:0] pr,
    input logic                  next_bit,
    input logic [DATA_WIDTH-1:0] dvs
  );
    logic [DATA_WIDTH:0]   trial;
    logic [DATA_WIDTH-1:0] diff;
    trial = {pr, next_bit};
    diff  = trial[DATA_WIDTH-1:0] - dvs;
    if (trial >= {1'b0, dvs}) begin
      div_step = {diff, 1'b1};
    end else begin
      div_step = {trial[DATA_WIDTH-1:0], 1'b0};
    end
  endfunction

  state_t                state_r, state_s;
  logic [FULL_WIDTH-1:0] dvd_r, dvd_s;
  logic [DATA_WIDTH-1:0] dvs_r, dvs_s;
  logic [DATA_WIDTH-1:0] pr_r, pr_s;
  logic [CNT_W-1:0]      cnt_r, cnt_s;
  logic                  busy_r, busy_s;
  logic                  done_r, done_s;
  logic                  dz_r, dz_s;
  logic [FULL_WIDTH-1:0] quo_r, quo_s;
  logic [DATA_WIDTH-1:0] rem_r, rem_s;
  logic [DATA_WIDTH:0]   step_s;

  // Next-state and next-output logic for the IDLE/RUN/DONE controller and datapath.
  always_comb begin
    state_s = state_r;
    dvd_s   = dvd_r;
    dvs_s   = dvs_r;
    pr_s    = pr_r;
    cnt_s   = cnt_r;
    busy_s  = busy_r;
    done_s  = done_r;
    dz_s    = dz_r;
    quo_s   = quo_r;
    rem_s   = rem_r;
    step_s  = div_step(pr_r, dvd_r[FULL_WIDTH-1], dvs_r);

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          dvd_s  = dividend;
          dvs_s  = divisor;
          pr_s   = {DATA_WIDTH{1'b0}};
          cnt_s  = CNT_ZERO;
          done_s = 1'b0;
          dz_s   = 1'b0;
          // A zero divisor skips RUN entirely and reports on the accepting edge.
          if (divisor == {DATA_WIDTH{1'b0}}) begin
            state_s = ST_DONE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
            dz_s    = 1'b1;
            quo_s   = {FULL_WIDTH{1'b1}};
            rem_s   = dividend[DATA_WIDTH-1:0];
          end else begin
            state_s = ST_RUN;
            busy_s  = 1'b1;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_RUN: begin
        pr_s  = step_s[DATA_WIDTH:1];
        dvd_s = {dvd_r[FULL_WIDTH-2:0], step_s[0]};
        if (cnt_r == CNT_LAST) begin
          state_s = ST_DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          quo_s   = {dvd_r[FULL_WIDTH-2:0], step_s[0]};
          rem_s   = step_s[DATA_WIDTH:1];
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        dz_s    = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      dvd_r   <= {FULL_WIDTH{1'b0}};
      dvs_r   <= {DATA_WIDTH{1'b0}};
      pr_r    <= {DATA_WIDTH{1'b0}};
      cnt_r   <= CNT_ZERO;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dz_r    <= 1'b0;
      quo_r   <= {FULL_WIDTH{1'b0}};
      rem_r   <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      dvd_r   <= dvd_s;
      dvs_r   <= dvs_s;
      pr_r    <= pr_s;
      cnt_r   <= cnt_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      dz_r    <= dz_s;
      quo_r   <= quo_s;
      rem_r   <= rem_s;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign div_zero  = dz_r;
  assign quotient  = quo_r;
  assign remainder = rem_r;

endmodule

// File: tb/tb_seq_divider_16bit.sv
// Self-checking bench for seq_divider_16bit: directed cases, inverse sweep, handshake,
// reset abort and random operands against an arithmetic reference model.
module tb_seq_divider_16bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] quotient;
  logic [15:0] remainder;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_divider_16bit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .quotient  (quotient),
    .remainder (remainder)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [31:0] a, input logic [15:0] b,
                       output logic [31:0] q, output logic [15:0] r, output logic dz);
    if (b == 16'd0) begin
      q  = 32'hFFFF_FFFF;
      r  = a[15:0];
      dz = 1'b1;
    end else begin
      q  = a / {16'd0, b};
      r  = 16'(a % {16'd0, b});
      dz = 1'b0;
    end
  endtask

  task automatic launch(input logic [31:0] a, input logic [15:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges (sampled #1 after each) until done, bounded so a stuck DUT still ends.
  task automatic wait_done(input int lat_in, output int lat);
    lat = lat_in;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [15:0] b, input string tag);
    logic [31:0] eq;
    logic [15:0] er;
    logic        edz;
    int          lat;
    model(a, b, eq, er, edz);
    launch(a, b);
    check({tag, ".busy_e0"}, 64'(busy), 64'(!edz));
    wait_done(0, lat);
    check({tag, ".latency"}, 64'(lat), edz ? 64'd0 : 64'd32);
    check({tag, ".quotient"}, 64'(quotient), 64'(eq));
    check({tag, ".remainder"}, 64'(remainder), 64'(er));
    check({tag, ".div_zero"}, 64'(div_zero), 64'(edz));
  endtask

  initial begin
    int          lat;
    logic [31:0] ra;
    logic [15:0] rb;

    rst      = 1'b1;
    start    = 1'b1;
    dividend = 32'd100;
    divisor  = 16'd7;
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.div_zero", 64'(div_zero), 64'd0);
    check("reset.quotient", 64'(quotient), 64'd0);
    check("reset.remainder", 64'(remainder), 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    run_op(32'd100, 16'd7, "dir1");
    check("dir1.q_const", 64'(quotient), 64'd14);
    check("dir1.r_const", 64'(remainder), 64'd2);
    run_op(32'hFFFF_FFFF, 16'd1, "dir2a");
    check("dir2a.q_const", 64'(quotient), 64'hFFFF_FFFF);
    run_op(32'hFFFF_FFFF, 16'hFFFF, "dir2b");
    check("dir2b.q_const", 64'(quotient), 64'h0001_0001);
    run_op(32'h0000_1234, 16'd0, "divzero");
    check("divzero.r_const", 64'(remainder), 64'h1234);
    run_op(32'd0, 16'd5, "dvd_zero");
    run_op(32'd3, 16'd9, "small_over_big");

    // Inverse sweep
    for (int i = 1; i <= 15; i++) begin
      for (int j = 1; j <= 15; j++) begin
        run_op(32'(i * j), 16'(j), $sformatf("sweep_exact_%0d_%0d", i, j));
        check($sformatf("sweep_exact_%0d_%0d.q_i", i, j), 64'(quotient), 64'(i));
        run_op(32'(i * j + j - 1), 16'(j), $sformatf("sweep_rem_%0d_%0d", i, j));
        check($sformatf("sweep_rem_%0d_%0d.r_j1", i, j), 64'(remainder), 64'(j - 1));
      end
    end

    // Handshake: operands and a start pulse mid-RUN must be ignored
    launch(32'd100, 16'd7);
    lat = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      lat++;
    end
    dividend = 32'd999;
    divisor  = 16'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    lat++;
    start = 1'b0;
    wait_done(lat, lat);
    check("hs.latency", 64'(lat), 64'd32);
    check("hs.quotient", 64'(quotient), 64'd14);
    check("hs.remainder", 64'(remainder), 64'd2);
    repeat (5) @(posedge clk);
    #1;
    check("hs.done_hold", 64'(done), 64'd1);
    check("hs.q_hold", 64'(quotient), 64'd14);

    // Back-to-back with start held high in DONE
    @(negedge clk);
    dividend = 32'd1000;
    divisor  = 16'd10;
    start    = 1'b1;
    @(posedge clk);
    #1;
    wait_done(0, lat);
    check("b2b.latency", 64'(lat), 64'd32);
    check("b2b.quotient", 64'(quotient), 64'd100);
    @(posedge clk);
    #1;
    check("b2b.done_fall", 64'(done), 64'd0);
    check("b2b.busy_rerun", 64'(busy), 64'd1);
    wait_done(0, lat);
    check("b2b.low_cycles", 64'(lat), 64'd32);
    start = 1'b0;

    // Reset 10 cycles into RUN
    launch(32'd100, 16'd7);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid.busy", 64'(busy), 64'd0);
    check("rst_mid.done", 64'(done), 64'd0);
    check("rst_mid.div_zero", 64'(div_zero), 64'd0);
    check("rst_mid.quotient", 64'(quotient), 64'd0);
    check("rst_mid.remainder", 64'(remainder), 64'd0);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("rst_mid.no_done", 64'(done), 64'd0);
    run_op(32'd100, 16'd7, "rst_fresh");

    // Random operands, with small and zero divisors mixed in
    for (int k = 0; k < 40; k++) begin
      ra = $urandom;
      if (k % 8 == 0) begin
        rb = 16'($urandom_range(0, 15));
      end else begin
        rb = 16'($urandom);
      end
      run_op(ra, rb, $sformatf("rand_%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
